// File: rtl/ni_link_tx_pkg.sv
// rtl/ni_link_tx_pkg.sv - shared widths, flit type encodings and FSM states for the NI transmit stage
package ni_link_tx_pkg;

    localparam logic V_ZERO = 1'b0;
    localparam logic V_ONE  = 1'b1;

    // Flit type encodings shared with the NI input buffer.
    typedef enum logic [1:0] {
        FT_HEADER      = 2'b00,
        FT_BODY        = 2'b01,
        FT_TAIL        = 2'b10,
        FT_HEADER_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    function automatic int width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int num_phits(input int flit_size, input int phit_size);
        return flit_size / phit_size;
    endfunction

endpackage

// File: rtl/ni_tx_fifo.sv
// rtl/ni_tx_fifo.sv - flit queue in front of the link serializer, with sticky overflow flag
module ni_tx_fifo
    import ni_link_tx_pkg::*;
#(
    parameter int FLIT_SIZE      = 64,
    parameter int FLIT_TYPE_SIZE = 2,
    parameter int QUEUE_SIZE     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FLIT_SIZE-1:0]      flit_in,
    input  logic [FLIT_TYPE_SIZE-1:0] type_in,
    input  logic                      bcast_in,
    input  logic                      valid_in,
    input  logic                      pop,
    output logic                      avail,
    output logic                      empty,
    output logic                      overflow,
    output logic [FLIT_SIZE-1:0]      head_flit,
    output logic [FLIT_TYPE_SIZE-1:0] head_type,
    output logic                      head_bcast
);

    localparam int PTR_W = width(QUEUE_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QUEUE_SIZE);

    logic [FLIT_SIZE-1:0]      mem_flit  [QUEUE_SIZE];
    logic [FLIT_TYPE_SIZE-1:0] mem_type  [QUEUE_SIZE];
    logic                      mem_bcast [QUEUE_SIZE];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;

    assign avail      = (count != FULL);
    assign empty      = (count == '0);
    assign push       = valid_in & avail;
    assign head_flit  = mem_flit[rd_ptr];
    assign head_type  = mem_type[rd_ptr];
    assign head_bcast = mem_bcast[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_flit[wr_ptr]  <= flit_in;
            mem_type[wr_ptr]  <= type_in;
            mem_bcast[wr_ptr] <= bcast_in;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= V_ZERO;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
            if (valid_in && !avail) overflow <= V_ONE;
        end
    end

endmodule

// File: rtl/ni_link_tx.sv
// rtl/ni_link_tx.sv - NI transmit stage: queues flits and serializes them LSB phit first under Stop&Go
module ni_link_tx
    import ni_link_tx_pkg::*;
#(
    parameter int ID             = 0,
    parameter int FLIT_SIZE      = 64,
    parameter int FLIT_TYPE_SIZE = 2,
    parameter int PHIT_SIZE      = 64,
    parameter int QUEUE_SIZE     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FLIT_SIZE-1:0]      FlitIn,
    input  logic [FLIT_TYPE_SIZE-1:0] FlitTypeIn,
    input  logic                      BroadcastIn,
    input  logic                      ValidIn,
    output logic                      Avail,
    input  logic                      Go,
    output logic [PHIT_SIZE-1:0]      Flit,
    output logic [FLIT_TYPE_SIZE-1:0] FlitType,
    output logic                      BroadcastFlit,
    output logic                      Valid,
    output logic                      Overflow
);

    localparam int NUM_PHITS = num_phits(FLIT_SIZE, PHIT_SIZE);
    localparam int CNT_W     = width(NUM_PHITS);
    localparam logic [CNT_W-1:0] LAST_PHIT = CNT_W'(NUM_PHITS - 1);

    tx_state_e                 state;
    logic [CNT_W-1:0]          phit_cnt;
    logic [FLIT_SIZE-1:0]      shreg;
    logic                      fifo_empty;
    logic [FLIT_SIZE-1:0]      head_flit;
    logic [FLIT_TYPE_SIZE-1:0] head_type;
    logic                      head_bcast;
    logic                      at_last;
    logic                      load;

    ni_tx_fifo #(
        .FLIT_SIZE      (FLIT_SIZE),
        .FLIT_TYPE_SIZE (FLIT_TYPE_SIZE),
        .QUEUE_SIZE     (QUEUE_SIZE)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flit_in    (FlitIn),
        .type_in    (FlitTypeIn),
        .bcast_in   (BroadcastIn),
        .valid_in   (ValidIn),
        .pop        (load),
        .avail      (Avail),
        .empty      (fifo_empty),
        .overflow   (Overflow),
        .head_flit  (head_flit),
        .head_type  (head_type),
        .head_bcast (head_bcast)
    );

    // Go is only consulted at flit boundaries; a started flit always completes.
    assign at_last = (state == ST_SEND) && (phit_cnt == LAST_PHIT);
    assign load    = !fifo_empty && Go && ((state == ST_IDLE) || at_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            phit_cnt      <= '0;
            shreg         <= '0;
            Flit          <= '0;
            FlitType      <= '0;
            BroadcastFlit <= V_ZERO;
            Valid         <= V_ZERO;
        end else if (load) begin
            state         <= ST_SEND;
            phit_cnt      <= '0;
            shreg         <= head_flit >> PHIT_SIZE;
            Flit          <= head_flit[PHIT_SIZE-1:0];
            FlitType      <= head_type;
            BroadcastFlit <= head_bcast;
            Valid         <= V_ONE;
        end else if ((state == ST_SEND) && !at_last) begin
            phit_cnt      <= phit_cnt + CNT_W'(1);
            shreg         <= shreg >> PHIT_SIZE;
            Flit          <= shreg[PHIT_SIZE-1:0];
        end else begin
            state         <= ST_IDLE;
            phit_cnt      <= '0;
            Flit          <= '0;
            FlitType      <= '0;
            BroadcastFlit <= V_ZERO;
            Valid         <= V_ZERO;
        end
    end

endmodule

// File: tb/tb_ni_link_tx.sv
// tb/tb_ni_link_tx.sv - self-checking bench for ni_link_tx (4-phit and 1-phit configurations)
module tb_ni_link_tx;
    import ni_link_tx_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [63:0] flit_in;
    logic [1:0]  type_in;
    logic        bcast_in, valid_in, go;
    logic        avail, bflit, valid, ovf;
    logic [15:0] flit;
    logic [1:0]  ftype;

    logic [63:0] flit_in_1;
    logic [1:0]  type_in_1;
    logic        bcast_in_1, valid_in_1, go_1;
    logic        avail_1, bflit_1, valid_1, ovf_1;
    logic [63:0] flit_1;
    logic [1:0]  ftype_1;

    ni_link_tx #(.ID(0), .FLIT_SIZE(64), .FLIT_TYPE_SIZE(2), .PHIT_SIZE(16), .QUEUE_SIZE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .FlitIn(flit_in), .FlitTypeIn(type_in), .BroadcastIn(bcast_in),
        .ValidIn(valid_in), .Avail(avail), .Go(go), .Flit(flit), .FlitType(ftype),
        .BroadcastFlit(bflit), .Valid(valid), .Overflow(ovf)
    );

    ni_link_tx #(.ID(1), .FLIT_SIZE(64), .FLIT_TYPE_SIZE(2), .PHIT_SIZE(64), .QUEUE_SIZE(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .FlitIn(flit_in_1), .FlitTypeIn(type_in_1), .BroadcastIn(bcast_in_1),
        .ValidIn(valid_in_1), .Avail(avail_1), .Go(go_1), .Flit(flit_1), .FlitType(ftype_1),
        .BroadcastFlit(bflit_1), .Valid(valid_1), .Overflow(ovf_1)
    );

    typedef struct packed { logic [15:0] phit; logic [1:0] ftype; logic bcast; } exp4_t;
    typedef struct packed { logic [63:0] phit; logic [1:0] ftype; logic bcast; } exp1_t;
    typedef struct packed {
        logic [63:0]      flit;
        logic [1:0]       ftype;
        logic             bcast;
        logic [3:0][15:0] phits;
    } vec_t;

    exp4_t q4[$];
    exp1_t q1[$];
    vec_t  vecs[4];
    int    vectors = 0;
    int    miscompares = 0;

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic present4(input logic [63:0] f, input logic [1:0] t, input logic b, input bit accept);
        flit_in = f; type_in = t; bcast_in = b; valid_in = 1'b1;
        if (accept)
            for (int k = 0; k < 4; k++) q4.push_back(exp4_t'{f[k*16 +: 16], t, b});
    endtask

    task automatic present1(input logic [63:0] f, input logic [1:0] t, input logic b);
        flit_in_1 = f; type_in_1 = t; bcast_in_1 = b; valid_in_1 = 1'b1;
        q1.push_back(exp1_t'{f, t, b});
    endtask

    // Scoreboards: every valid phit must match the oldest expected phit; idle bus must be zero.
    always @(negedge clk) begin
        exp4_t e;
        if (rst_n) begin
            if (valid) begin
                if (q4.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL sb4_unexpected: got phit %h, expected no phit", flit);
                end else begin
                    e = q4.pop_front();
                    check("sb4_phit", {flit, ftype, bflit}, e);
                end
            end else begin
                check("sb4_idle_zero", {flit, ftype, bflit}, '0);
            end
        end
    end

    always @(negedge clk) begin
        exp1_t e;
        if (rst_n && valid_1) begin
            if (q1.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL sb1_unexpected: got flit %h, expected no flit", flit_1);
            end else begin
                e = q1.pop_front();
                check("sb1_flit", {flit_1, ftype_1, bflit_1}, e);
            end
        end
    end

    int run;
    bit ended;
    int n1;

    initial begin
        vecs[0] = '{64'h4444_3333_2222_1111, 2'b01, 1'b1, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
        vecs[1] = '{64'hDEAD_BEEF_0123_4567, 2'b10, 1'b0, {16'hDEAD, 16'hBEEF, 16'h0123, 16'h4567}};
        vecs[2] = '{64'hFFFF_0000_FFFF_0000, 2'b11, 1'b1, {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000}};
        vecs[3] = '{64'h0000_0000_0000_0001, 2'b00, 1'b0, {16'h0000, 16'h0000, 16'h0000, 16'h0001}};

        rst_n = 1'b0; go = 1'b0; valid_in = 1'b0; flit_in = '0; type_in = '0; bcast_in = 1'b0;
        go_1 = 1'b0; valid_in_1 = 1'b0; flit_in_1 = '0; type_in_1 = '0; bcast_in_1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_flit", flit, 0);
        check("rst_ovf", ovf, 0);
        check("rst_valid1", valid_1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_avail", avail, 1);
        check("rst_avail1", avail_1, 1);

        // Table: single flits, latency and per-phit content.
        go = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("tbl_avail", avail, 1);
            present4(vecs[i].flit, vecs[i].ftype, vecs[i].bcast, 1'b1);
            @(negedge clk);
            valid_in = 1'b0;
            check("tbl_latency", valid, 0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("tbl_phit", {valid, flit, ftype, bflit},
                      {1'b1, vecs[i].phits[k], vecs[i].ftype, vecs[i].bcast});
            end
            @(negedge clk);
            check("tbl_done", valid, 0);
        end

        // Back-to-back: three flits give 12 valid cycles without a bubble.
        run = 0; ended = 1'b0;
        for (int i = 0; i < 3; i++) begin
            present4({16'(16'hB000 + i), 16'(16'hB100 + i), 16'(16'hB200 + i), 16'(16'hB300 + i)}, 2'(i), 1'b0, 1'b1);
            @(negedge clk);
            if (valid) run++;
            check("b2b_avail", avail, 1);
        end
        valid_in = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (valid && !ended) run++;
            else if (run > 0) ended = 1'b1;
            check("b2b_avail", avail, 1);
        end
        check("b2b_run", run, 12);

        // Stop&Go: Go drops mid-flit, remaining phits still go, next flit waits.
        present4(64'hAAAA_BBBB_CCCC_DDDD, 2'b10, 1'b0, 1'b1);
        @(negedge clk);
        present4(64'h1234_5678_9ABC_DEF0, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        check("sg_p0", valid, 1);
        @(negedge clk); check("sg_p1", valid, 1); go = 1'b0;
        @(negedge clk); check("sg_p2", valid, 1);
        @(negedge clk); check("sg_p3", valid, 1);
        repeat (3) begin @(negedge clk); check("sg_hold", valid, 0); end
        go = 1'b1;
        @(negedge clk); check("sg_resume", valid, 1);
        repeat (3) begin @(negedge clk); check("sg_rest", valid, 1); end
        @(negedge clk); check("sg_end", valid, 0);

        // Full queue with Go low: fifth push is dropped and sets Overflow.
        go = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("ovf_avail", avail, (i < 4));
            check("ovf_flag_clear", ovf, 0);
            present4({16'(16'h4000 + i), 16'(16'h3000 + i), 16'(16'h2000 + i), 16'(16'h1000 + i)},
                     2'(i), i[0], (i < 4));
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("ovf_full", avail, 0);
        check("ovf_sticky", ovf, 1);
        go = 1'b1;
        @(negedge clk);
        check("ovf_first_pop_avail", avail, 1);
        check("ovf_first_valid", valid, 1);
        for (int c = 0; c < 40 && q4.size() != 0; c++) @(negedge clk);
        @(negedge clk);
        check("ovf_drained", q4.size(), 0);
        check("ovf_still_set", ovf, 1);

        // One phit per flit: a push every cycle streams straight through.
        go_1 = 1'b1; n1 = 0;
        for (int i = 0; i < 10; i++) begin
            present1({$urandom, $urandom}, 2'(i), i[0]);
            @(negedge clk);
            if (valid_1) n1++;
            check("np1_avail", avail_1, 1);
            check("np1_ovf", ovf_1, 0);
        end
        valid_in_1 = 1'b0;
        repeat (3) begin @(negedge clk); if (valid_1) n1++; end
        check("np1_count", n1, 10);
        check("np1_sb_empty", q1.size(), 0);

        // Reset in the middle of a flit aborts it with no trailing phits.
        present4(64'h5555_6666_7777_8888, 2'b01, 1'b0, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", valid, 0);
        check("mrst_flit", flit, 0);
        check("mrst_ovf", ovf, 0);
        q4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("mrst_idle", valid, 0);
            check("mrst_avail", avail, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
